// File: rtl/seq_det_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_det_pkg : shared types and constants for the 1011 round-robin detector
// Rev 1.0
// ---------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam logic [3:0] PATTERN  = 4'b1011;
  localparam int         DEF_N_CH = 4;

endpackage
`default_nettype wire

// File: rtl/seq_det_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_det_step : combinational (state, bit) -> (next state, match) for 1011
// Rev 1.0
// ---------------------------------------------------------------------------
module seq_det_step
  import seq_det_pkg::*;
(
  input  state_t i_state,
  input  logic   i_bit,
  output state_t o_next,
  output logic   o_match
);

  // Each state is the length of the longest pattern prefix seen as a suffix.
  always_comb begin
    o_next  = S0;
    o_match = 1'b0;
    case (i_state)
      S0: o_next = (i_bit == PATTERN[3]) ? S1 : S0;
      S1: o_next = (i_bit == PATTERN[2]) ? S2 : S1;
      S2: o_next = (i_bit == PATTERN[1]) ? S3 : S0;
      S3: begin
        if (i_bit == PATTERN[0]) begin
          o_next  = S1;
          o_match = 1'b1;
        end else begin
          o_next  = S2;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_det_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_det_sched : round-robin sharing of one 1011 matcher across N_CH streams
// Optional per-channel match counters: define SEQ_DET_SCHED_MATCH_CNT_EN
// Rev 1.0
// ---------------------------------------------------------------------------
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CH_W  = 2
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
  , parameter int CNT_W = 8
`endif
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] ch_valid,
  input  logic [N_CH-1:0] ch_data,
  input  logic [N_CH-1:0] ch_clr,
  output logic [N_CH-1:0] ch_ready,
  output logic            det_valid,
  output logic [CH_W-1:0] det_ch,
  output logic            busy
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
  , input  logic [CH_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0] cnt_data,
  input  logic             cnt_clr
`endif
);

  state_t            r_ctx [N_CH];
  logic [CH_W-1:0]   r_rr_ptr;

  logic [N_CH-1:0]   w_elig;
  logic [N_CH-1:0]   w_onehot;
  logic [CH_W-1:0]   w_gnt;
  logic              w_found;
  state_t            w_sel_state;
  logic              w_sel_bit;
  state_t            w_next;
  logic              w_match;
  logic [CH_W-1:0]   w_ptr_nxt;

  assign w_elig = ch_valid & ~ch_clr;

  // Pick the eligible channel with the smallest circular distance from r_rr_ptr.
  always_comb begin
    int best_d;
    w_onehot    = '0;
    w_gnt       = '0;
    w_found     = 1'b0;
    w_sel_state = S0;
    w_sel_bit   = 1'b0;
    best_d      = N_CH;
    for (int i = 0; i < N_CH; i++) begin
      int d;
      d = i - int'(r_rr_ptr);
      if (d < 0) d = d + N_CH;
      if (w_elig[i] && (d < best_d)) begin
        best_d      = d;
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
        w_gnt       = CH_W'(i);
        w_found     = 1'b1;
        w_sel_state = r_ctx[i];
        w_sel_bit   = ch_data[i];
      end
    end
  end

  assign ch_ready  = rst ? '0 : w_onehot;
  assign w_ptr_nxt = (w_gnt == CH_W'(N_CH - 1)) ? '0 : w_gnt + 1'b1;

  seq_det_step u_step (
    .i_state (w_sel_state),
    .i_bit   (w_sel_bit),
    .o_next  (w_next),
    .o_match (w_match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_ctx[i] <= S0;
      r_rr_ptr  <= '0;
      det_valid <= 1'b0;
      det_ch    <= '0;
      busy      <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_clr[i])
          r_ctx[i] <= S0;
        else if (w_found && (w_gnt == CH_W'(i)))
          r_ctx[i] <= w_next;
      end
      det_valid <= w_found & w_match;
      if (w_found && w_match) det_ch <= w_gnt;
      busy <= w_found;
      if (w_found) r_rr_ptr <= w_ptr_nxt;
    end
  end

`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt [N_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_clr || ch_clr[i])
          r_cnt[i] <= '0;
        else if (w_found && w_match && (w_gnt == CH_W'(i)) && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // Selects past the last channel fall through to zero.
  always_comb begin
    cnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cnt_sel == CH_W'(i)) cnt_data = r_cnt[i];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_det_sched : vector table, hand sequences and random run vs. model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_det_sched;

  localparam int N  = 4;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] ch_valid = '0;
  logic [N-1:0] ch_data  = '0;
  logic [N-1:0] ch_clr   = '0;
  logic [N-1:0] ch_ready;
  logic         det_valid;
  logic [CW-1:0] det_ch;
  logic         busy;

  logic [2:0]   v3 = '0;
  logic [2:0]   d3 = '0;
  logic [2:0]   c3 = '0;
  logic [2:0]   rdy3;
  logic         dv3;
  logic [1:0]   dch3;
  logic         busy3;

`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
  logic [CW-1:0] cnt_sel  = '0;
  logic [1:0]    cnt_sel3 = '0;
  logic          cnt_clr  = 1'b0;
  logic [7:0]    cnt_data;
  logic [7:0]    cnt_data3;
`endif

  always #5 clk = ~clk;

  seq_det_sched #(
    .N_CH (N),
    .CH_W (CW)
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
    , .CNT_W (8)
`endif
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_clr    (ch_clr),
    .ch_ready  (ch_ready),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .busy      (busy)
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
    , .cnt_sel  (cnt_sel),
    .cnt_data (cnt_data),
    .cnt_clr  (cnt_clr)
`endif
  );

  seq_det_sched #(
    .N_CH (3),
    .CH_W (2)
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
    , .CNT_W (8)
`endif
  ) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (v3),
    .ch_data   (d3),
    .ch_clr    (c3),
    .ch_ready  (rdy3),
    .det_valid (dv3),
    .det_ch    (dch3),
    .busy      (busy3)
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
    , .cnt_sel  (cnt_sel3),
    .cnt_data (cnt_data3),
    .cnt_clr  (cnt_clr)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a channel matches when its last four consumed bits read 1011.
  int         m_rr;
  logic [3:0] m_hist [N];
  logic       m_dv;
  int         m_dch;
  logic       m_busy;

  task automatic m_reset();
    m_rr = 0; m_dv = 1'b0; m_dch = 0; m_busy = 1'b0;
    for (int i = 0; i < N; i++) m_hist[i] = 4'b0000;
  endtask

  function automatic int m_grant(input logic [N-1:0] v, input logic [N-1:0] c);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (v[idx] && !c[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic m_step(input logic [N-1:0] v, input logic [N-1:0] d, input logic [N-1:0] c);
    int g;
    g = m_grant(v, c);
    for (int i = 0; i < N; i++) if (c[i]) m_hist[i] = 4'b0000;
    if (g >= 0) begin
      m_hist[g] = {m_hist[g][2:0], d[g]};
      m_dv      = (m_hist[g] == 4'b1011);
      if (m_dv) m_dch = g;
      m_busy    = 1'b1;
      m_rr      = (g + 1) % N;
    end else begin
      m_dv   = 1'b0;
      m_busy = 1'b0;
    end
  endtask

  // Entered and left at posedge+1.
  task automatic do_cycle(input logic [N-1:0] v, input logic [N-1:0] d,
                          input logic [N-1:0] c, output logic [N-1:0] rdy);
    int g;
    logic [N-1:0] exp_rdy;
    ch_valid = v; ch_data = d; ch_clr = c;
    #3;
    rdy = ch_ready;
    g = m_grant(v, c);
    exp_rdy = (g < 0) ? '0 : (N'(1) << g);
    chk("ch_ready", rdy, exp_rdy);
    @(posedge clk); #1;
    m_step(v, d, c);
    chk("det_valid", det_valid, m_dv);
    if (m_dv) chk("det_ch", det_ch, m_dch);
    chk("busy", busy, m_busy);
  endtask

  task automatic do_reset();
    ch_valid = '0; ch_data = '0; ch_clr = '0;
    v3 = '0; d3 = '0; c3 = '0;
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst_ready", ch_ready, 0);
    chk("rst_det_valid", det_valid, 0);
    chk("rst_det_ch", det_ch, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rb;
    logic [3:0] v, d, c, rdy;
    logic       dv;
    logic [1:0] dch;
  } vec_t;

  function automatic vec_t mk(input logic rb, input logic [3:0] v, input logic [3:0] d,
                              input logic [3:0] c, input logic [3:0] rdy,
                              input logic dv, input logic [1:0] dch);
    vec_t e;
    e.rb = rb; e.v = v; e.d = d; e.c = c; e.rdy = rdy; e.dv = dv; e.dch = dch;
    return e;
  endfunction

  initial begin
    vec_t         tbl[$];
    logic [N-1:0] rdy;
    logic [3:0]   pat;
    logic [6:0]   bits0;
    logic [2:0]   exp3 [4];

    // Channel 0 alone streams 1011011: matches after bits 4 and 7.
    bits0 = 7'b1011011;
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(k == 0, 4'b0001, {3'b000, bits0[6-k]}, 4'b0000, 4'b0001,
                       (k == 3) || (k == 6), 2'd0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));
    // All channels valid from rr_ptr 0, each fed 1011: rotating grants, four pulses.
    pat = 4'b1011;
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(k == 0, 4'b1111, {4{pat[3 - k/4]}}, 4'b0000, 4'(1 << (k % 4)),
                       k >= 12, 2'(k % 4)));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));

    m_reset();
    @(posedge clk); #1;
    chk("init_ready", ch_ready, 0);
    chk("init_det_valid", det_valid, 0);
    chk("init_busy", busy, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].rb) do_reset();
      do_cycle(tbl[i].v, tbl[i].d, tbl[i].c, rdy);
      chk($sformatf("tbl%0d_ready", i), rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_dv", i), det_valid, tbl[i].dv);
      if (tbl[i].dv) chk($sformatf("tbl%0d_dch", i), det_ch, tbl[i].dch);
    end

    // Clear on channel 2 after 101; channel 1 still granted in the clear cycle.
    do_reset();
    do_cycle(4'b0100, 4'b0100, 4'b0000, rdy);
    do_cycle(4'b0100, 4'b0000, 4'b0000, rdy);
    do_cycle(4'b0100, 4'b0100, 4'b0000, rdy);
    do_cycle(4'b0110, 4'b0100, 4'b0100, rdy);
    chk("clr_ready", rdy, 4'b0010);
    chk("clr_dv", det_valid, 0);
    do_cycle(4'b0100, 4'b0100, 4'b0000, rdy);
    chk("after_clr_ready", rdy, 4'b0100);
    chk("after_clr_dv", det_valid, 0);
    do_cycle(4'b0100, 4'b0000, 4'b0000, rdy);
    do_cycle(4'b0100, 4'b0100, 4'b0000, rdy);
    do_cycle(4'b0100, 4'b0100, 4'b0000, rdy);
    chk("restart_dv", det_valid, 1);
    chk("restart_dch", det_ch, 2);

    // Asynchronous reset mid-cycle after channel 1 has seen 101.
    do_reset();
    do_cycle(4'b0010, 4'b0010, 4'b0000, rdy);
    do_cycle(4'b0010, 4'b0000, 4'b0000, rdy);
    do_cycle(4'b0010, 4'b0010, 4'b0000, rdy);
    ch_valid = 4'b0010; ch_data = 4'b0010;
    #2; rst = 1'b1;
    #1; chk("arst_ready", ch_ready, 0);
    #1; chk("arst_dv", det_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_dch", det_ch, 0);
    m_reset();
    @(posedge clk); #3;
    chk("arst_hold_dv", det_valid, 0);
    chk("arst_hold_ready", ch_ready, 0);
    rst = 1'b0;
    ch_valid = '0; ch_data = '0;
    @(posedge clk); #1;
    do_cycle(4'b0010, 4'b0010, 4'b0000, rdy);
    chk("post_arst_dv", det_valid, 0);
    do_cycle(4'b1111, 4'b0000, 4'b0000, rdy);
    chk("post_arst_rr", rdy, 4'b0100);

    // Three-channel instance: rr_ptr parked at 2, then channels 1 and 2 alternate.
    do_reset();
    v3 = 3'b010; #3;
    chk("n3_first", rdy3, 3'b010);
    @(posedge clk); #1;
    exp3[0] = 3'b100; exp3[1] = 3'b010; exp3[2] = 3'b100; exp3[3] = 3'b010;
    v3 = 3'b110;
    for (int k = 0; k < 4; k++) begin
      #3; chk($sformatf("n3_grant%0d", k), rdy3, exp3[k]);
      @(posedge clk); #1;
    end
    chk("n3_busy", busy3, 1);
    v3 = '0;
    @(posedge clk); #1;
    chk("n3_idle_busy", busy3, 0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] c;
      c = ($urandom_range(0, 11) == 0) ? N'(1 << $urandom_range(0, N-1)) : '0;
      do_cycle(N'($urandom), N'($urandom), c, rdy);
    end

`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
    // Channel 3 matches 300 times: counter saturates at 255.
    do_reset();
    do_cycle(4'b1000, 4'b1000, 4'b0000, rdy);
    do_cycle(4'b1000, 4'b0000, 4'b0000, rdy);
    do_cycle(4'b1000, 4'b1000, 4'b0000, rdy);
    do_cycle(4'b1000, 4'b1000, 4'b0000, rdy);
    cnt_sel = 2'd3; #1;
    chk("cnt_first", cnt_data, 1);
    for (int k = 0; k < 299; k++) begin
      do_cycle(4'b1000, 4'b0000, 4'b0000, rdy);
      do_cycle(4'b1000, 4'b1000, 4'b0000, rdy);
      do_cycle(4'b1000, 4'b1000, 4'b0000, rdy);
    end
    ch_valid = '0;
    chk("cnt_sat", cnt_data, 255);
    cnt_sel = 2'd0; #1;
    chk("cnt_other", cnt_data, 0);
    cnt_sel3 = 2'd3; #1;
    chk("cnt_out_of_range", cnt_data3, 0);
    cnt_sel = 2'd3;
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_clr", cnt_data, 0);
    do_cycle(4'b1000, 4'b0000, 4'b0000, rdy);
    do_cycle(4'b1000, 4'b1000, 4'b0000, rdy);
    do_cycle(4'b1000, 4'b0000, 4'b0000, rdy);
    do_cycle(4'b1000, 4'b1000, 4'b0000, rdy);
    do_cycle(4'b1000, 4'b1000, 4'b0000, rdy);
    chk("cnt_after_clr", cnt_data, 1);
    do_cycle(4'b0000, 4'b0000, 4'b1000, rdy);
    chk("cnt_ch_clr", cnt_data, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
